// File: rtl/rtc_alarm_clock_if.sv
// Control inputs and display outputs of the alarm clock core.
// The master drives the buttons; the slave (core) drives the digits.
interface rtc_alarm_clock_if;
  logic       en;
  logic       hrup;
  logic       minup;
  logic       set_alarm;
  logic       alarm_en;
  logic       snooze;
  logic       mode12;
  logic [3:0] s1, s2, m1, m2, h1, h2;
  logic       pm;
  logic       alarm_on;
  logic       tick;

  modport master (
    output en, hrup, minup, set_alarm, alarm_en, snooze, mode12,
    input  s1, s2, m1, m2, h1, h2, pm, alarm_on, tick
  );

  modport slave (
    input  en, hrup, minup, set_alarm, alarm_en, snooze, mode12,
    output s1, s2, m1, m2, h1, h2, pm, alarm_on, tick
  );
endinterface

// File: rtl/rtc_alarm_clock.sv
// 24-hour clock with prescaler, edge-triggered time/alarm setting, 12/24-hour BCD display
// and an alarm state machine with ring timeout and snooze.
module rtc_alarm_clock #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned RING_SECS     = 60,
  parameter int unsigned SNOOZE_MIN    = 5
) (
  input logic               clk,
  input logic               rst,
  rtc_alarm_clock_if.slave  bus
);

  localparam int unsigned PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PresLast = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]  RingLast   = 8'(RING_SECS - 1);
  localparam logic [11:0] SnoozeLast = 12'(SNOOZE_MIN * 60 - 1);

  typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} state_e;

  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic [5:0]    sec_q, min_q, al_min_q;
  logic [4:0]    hour_q, al_hour_q;
  logic          hrup_q, minup_q, snooze_q;
  state_e        state_q;
  logic [7:0]    ring_q;
  logic [11:0]   snz_q;
  logic          alarm_on_q;

  logic [5:0] sec_d, min_d;
  logic [4:0] hour_d;
  logic       hr_edge, min_edge, snz_edge, sec_tick, time_edit, alarm_hit;

  assign hr_edge   = bus.hrup & ~hrup_q;
  assign min_edge  = bus.minup & ~minup_q;
  assign snz_edge  = bus.snooze & ~snooze_q;
  assign sec_tick  = bus.en && (presc_q == PresLast);
  assign time_edit = ~bus.set_alarm & (hr_edge | min_edge);

  // A time edit swallows a coincident second advance.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (time_edit) begin
      if (min_edge) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (hr_edge)  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end else if (sec_tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  assign alarm_hit = sec_tick & ~time_edit & (sec_d == 6'd0) &
                     (min_d == al_min_q) & (hour_d == al_hour_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      al_min_q  <= '0;
      al_hour_q <= '0;
      hrup_q    <= bus.hrup;
      minup_q   <= bus.minup;
      snooze_q  <= bus.snooze;
    end else begin
      if (bus.en) presc_q <= (presc_q == PresLast) ? '0 : presc_q + PW'(1);
      tick_q   <= sec_tick;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      hrup_q   <= bus.hrup;
      minup_q  <= bus.minup;
      snooze_q <= bus.snooze;
      if (bus.set_alarm && min_edge)
        al_min_q <= (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
      if (bus.set_alarm && hr_edge)
        al_hour_q <= (al_hour_q == 5'd23) ? 5'd0 : al_hour_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ring_q     <= '0;
      snz_q      <= '0;
      alarm_on_q <= 1'b0;
    end else if (!bus.alarm_en) begin
      state_q    <= StIdle;
      alarm_on_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (alarm_hit) begin
            state_q    <= StRinging;
            ring_q     <= '0;
            alarm_on_q <= 1'b1;
          end
        end
        StRinging: begin
          if (snz_edge) begin
            state_q    <= StSnoozed;
            snz_q      <= '0;
            alarm_on_q <= 1'b0;
          end else if (sec_tick) begin
            if (ring_q == RingLast) begin
              state_q    <= StIdle;
              alarm_on_q <= 1'b0;
            end else begin
              ring_q <= ring_q + 8'd1;
            end
          end
        end
        StSnoozed: begin
          if (sec_tick) begin
            if (snz_q == SnoozeLast) begin
              state_q    <= StRinging;
              ring_q     <= '0;
              alarm_on_q <= 1'b1;
            end else begin
              snz_q <= snz_q + 12'd1;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          alarm_on_q <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [3:0] tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] ones(input logic [5:0] v);
    logic [5:0] t;
    t = v % 6'd10;
    return t[3:0];
  endfunction

  logic [4:0] disp_hour, hour_shown;
  logic [5:0] disp_min, disp_sec;
  logic       pm_w;

  always_comb begin
    disp_hour  = bus.set_alarm ? al_hour_q : hour_q;
    disp_min   = bus.set_alarm ? al_min_q : min_q;
    disp_sec   = bus.set_alarm ? 6'd0 : sec_q;
    hour_shown = disp_hour;
    pm_w       = 1'b0;
    if (bus.mode12) begin
      if (disp_hour == 5'd0) begin
        hour_shown = 5'd12;
      end else if (disp_hour >= 5'd12) begin
        pm_w = 1'b1;
        if (disp_hour > 5'd12) hour_shown = disp_hour - 5'd12;
      end
    end
  end

  assign bus.s1       = ones(disp_sec);
  assign bus.s2       = tens(disp_sec);
  assign bus.m1       = ones(disp_min);
  assign bus.m2       = tens(disp_min);
  assign bus.h1       = ones({1'b0, hour_shown});
  assign bus.h2       = tens({1'b0, hour_shown});
  assign bus.pm       = pm_w;
  assign bus.alarm_on = alarm_on_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Scoreboard bench for rtc_alarm_clock: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_rtc_alarm_clock;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtc_alarm_clock_if bus ();

  rtc_alarm_clock #(
    .TICKS_PER_SEC(4),
    .RING_SECS    (3),
    .SNOOZE_MIN   (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // field 0: {h2,h1,m2,m1,s2,s1}; 1: {pm,alarm_on}; 2: tick count; 3: tick level
  typedef struct {
    string       name;
    int          field;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    errors   = 0;
  int    checks   = 0;
  int    tick_cnt = 0;

  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    if (bus.tick === 1'b1) tick_cnt++;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.field)
        0:       act = {8'h00, bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1};
        1:       act = {30'd0, bus.pm, bus.alarm_on};
        2:       act = tick_cnt;
        default: act = {31'd0, bus.tick};
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", it.name, act, it.exp);
      end
    end
  end

  task automatic chk(input string name, input int field, input logic [31:0] exp);
    sb.push_back('{name, field, exp});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(posedge clk);
        #1;
        if (bus.tick) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL tick_timeout: no tick within 8 cycles (wait %0d of %0d)", k + 1, n);
      end
    end
  endtask

  task automatic press_hr(input int n);
    repeat (n) begin
      bus.hrup = 1'b1; step(1);
      bus.hrup = 1'b0; step(1);
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      bus.minup = 1'b1; step(1);
      bus.minup = 1'b0; step(1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.hrup = 1'b0;
    bus.minup = 1'b0;
    bus.set_alarm = 1'b0;
    bus.alarm_en = 1'b0;
    bus.snooze = 1'b0;
    bus.mode12 = 1'b0;
    step(3);
    checks++;
    if ({bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1} !== 24'h000000 ||
        bus.pm !== 1'b0 || bus.alarm_on !== 1'b0 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits 0x%0h pm %b alarm_on %b tick %b",
               {bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1}, bus.pm, bus.alarm_on,
               bus.tick);
    end
    chk("reset_digits", 0, 32'h000000);
    chk("reset_alarm", 1, 32'd0);
    chk("reset_ticks", 2, 32'd0);
    settle();

    // 240 enabled cycles at 4 cycles/second -> one minute
    @(posedge clk); #1;
    rst = 1'b0;
    step(240);
    chk("one_minute", 0, 32'h000100);
    chk("ticks_240cyc", 2, 32'd60);
    settle();

    // Preload 23:59:58 and roll over the day
    wait_ticks(58);
    bus.en = 1'b0;
    press_hr(23);
    press_min(58);
    chk("preload", 0, 32'h235958);
    settle();
    bus.en = 1'b1;
    wait_ticks(2);
    chk("day_rollover", 0, 32'h000000);
    settle();
    bus.en = 1'b0;
    step(20);
    chk("frozen_time", 0, 32'h000000);
    chk("frozen_ticks", 2, 32'd120);
    settle();

    // Held minup counts once
    bus.minup = 1'b1; step(10);
    bus.minup = 1'b0; step(1);
    chk("minup_held", 0, 32'h000100);
    settle();

    // minup edge on the tick that would wrap sec 59
    bus.en = 1'b1;
    wait_ticks(59);
    step(3);
    bus.minup = 1'b1;
    step(1);
    chk("edit_vs_tick", 0, 32'h000259);
    chk("tick_still_pulses", 3, 32'd1);
    chk("tick_count", 2, 32'd180);
    settle();
    bus.minup = 1'b0;

    // Alarm at 00:01, rings for 3 seconds
    rst = 1'b1; bus.en = 1'b0;
    step(2);
    rst = 1'b0;
    bus.set_alarm = 1'b1;
    press_min(1);
    chk("alarm_display", 0, 32'h000100);
    settle();
    bus.set_alarm = 1'b0;
    chk("time_display", 0, 32'h000000);
    settle();
    bus.alarm_en = 1'b1;
    bus.en = 1'b1;
    wait_ticks(59);
    chk("pre_alarm", 1, 32'd0);
    chk("pre_alarm_time", 0, 32'h000059);
    wait_ticks(1);
    chk("alarm_rise", 1, 32'd1);
    chk("alarm_time", 0, 32'h000100);
    wait_ticks(2);
    chk("alarm_ringing", 1, 32'd1);
    wait_ticks(1);
    chk("ring_timeout", 1, 32'd0);

    // Alarm at 00:02, snooze, re-ring after one minute
    bus.set_alarm = 1'b1;
    press_min(1);
    bus.set_alarm = 1'b0;
    wait_ticks(57);
    chk("alarm2_rise", 1, 32'd1);
    bus.snooze = 1'b1;
    step(1);
    chk("snoozed", 1, 32'd0);
    settle();
    bus.snooze = 1'b0;
    wait_ticks(59);
    chk("still_snoozed", 1, 32'd0);
    wait_ticks(1);
    chk("snooze_rering", 1, 32'd1);
    bus.alarm_en = 1'b0;
    step(1);
    chk("alarm_disable", 1, 32'd0);
    settle();

    // Reset while ringing
    bus.en = 1'b0;
    bus.alarm_en = 1'b1;
    bus.set_alarm = 1'b1;
    press_min(2);
    bus.set_alarm = 1'b0;
    bus.en = 1'b1;
    wait_ticks(60);
    chk("alarm3_rise", 1, 32'd1);
    settle();
    rst = 1'b1;
    step(1);
    chk("rst_ring_digits", 0, 32'h000000);
    chk("rst_ring_alarm", 1, 32'd0);
    settle();
    rst = 1'b0;
    bus.alarm_en = 1'b0;
    bus.en = 1'b0;

    // 12-hour display
    bus.mode12 = 1'b1;
    step(1);
    chk("h0_12h", 0, 32'h120000);
    chk("h0_pm", 1, 32'd0);
    settle();
    press_hr(11);
    chk("h11_12h", 0, 32'h110000);
    chk("h11_pm", 1, 32'd0);
    settle();
    press_hr(1);
    chk("h12_12h", 0, 32'h120000);
    chk("h12_pm", 1, 32'd2);
    settle();
    press_hr(1);
    chk("h13_12h", 0, 32'h010000);
    chk("h13_pm", 1, 32'd2);
    settle();
    press_hr(10);
    chk("h23_12h", 0, 32'h110000);
    chk("h23_pm", 1, 32'd2);
    settle();
    bus.mode12 = 1'b0;
    chk("h23_24h", 0, 32'h230000);
    chk("h23_24h_pm", 1, 32'd0);
    settle();
    press_hr(1);
    chk("hour_wrap", 0, 32'h000000);
    settle();

    // Simultaneous hour and minute edges
    bus.hrup = 1'b1; bus.minup = 1'b1; step(1);
    bus.hrup = 1'b0; bus.minup = 1'b0; step(1);
    chk("both_edges", 0, 32'h010100);
    settle();
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
